ram_to_mem_loader: RTL and testbench
====================================

Name: ram_to_mem_loader

Overview:
Parametrised successor to the layer loader. It streams a contiguous region of the external parameter RAM into the pixel database or the weight database. In weight mode it packs a configurable number of words (a conv kernel or a dense row segment) into one wide word before writing. One read is issued per clock, the RAM read latency is configurable, and a start/busy/done handshake replaces nextstep/GO sequencing; the top-level layer controller supplies base, length and mode per job.

Parameters:
DATA_W, 11, width of one RAM word / pixel (dp width)
KERNEL_N, 9, max words packed per weight write; dw width = DATA_W*KERNEL_N
ADDR_W, 13, external RAM address width
PIX_ADDR_W, 13, pixel database address width
WEI_ADDR_W, 10, weight database address width
RD_LAT, 1, RAM read latency in cycles (1..3)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle job request, sampled only in IDLE
mode  in  1  0 = pixel job, 1 = weight job; latched at start
base_addr  in  ADDR_W  first RAM address of job; latched at start
word_count  in  ADDR_W  words to transfer (0 = empty job); latched at start
group_len  in  4  words per packed weight; 0 or >KERNEL_N means KERNEL_N; latched
ram_addr  out  ADDR_W  RAM read address
ram_re  out  1  RAM read enable
ram_data  in  DATA_W signed  RAM read data, valid RD_LAT cycles after ram_re
we_p  out  1  pixel write strobe
dp  out  DATA_W signed  pixel data
addrp  out  PIX_ADDR_W  pixel address = word index in job
we_w  out  1  weight write strobe
dw  out  DATA_W*KERNEL_N signed  packed weight, first word in MSB lane
addrw  out  WEI_ADDR_W  weight address = group index in job
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters and pack buffer cleared; rst mid-job aborts the job with no further writes and no done pulse.
- States: IDLE -> (start, word_count!=0) ISSUE -> (last read issued) DRAIN -> (last returned word written/flushed) DONE -> IDLE. start with word_count==0: IDLE -> DONE directly (busy high 1 cycle, done pulse, no writes).
- ISSUE: ram_re=1 every cycle; ram_addr = base_addr + rd_idx, with rd_idx counting 0..word_count-1; addresses wrap modulo 2^ADDR_W.
- Return path: an RD_LAT-deep valid shift register tracks reads. A returned word is sampled at the edge RD_LAT cycles after its ram_re edge.
- Pixel mode: on each sampled word, the next cycle shows we_p=1, dp=word, addrp=wr_idx. Throughput is 1 word/clk. First we_p appears RD_LAT+1 cycles after the start edge.
- Weight mode: each word is loaded into lane L, starting at L=0 = bits [DATA_W*KERNEL_N-1 : DATA_W*(KERNEL_N-1)] and descending. When L reaches group_len-1, we_w pulses with dw=buffer; lanes >= group_len are zero. addrw then increments and the buffer clears.
- Partial final group (word_count not a multiple of group_len): flushed in DRAIN as one extra we_w, with unfilled lanes zero.
- Write strobes are single-cycle. Strobes are 0 in IDLE/DONE and in cycles with no returned data. dp, dw, addrp and addrw hold their last value.
- done pulses in the cycle after the final write strobe, and busy falls with it. start is ignored while busy or in DONE.
- Address counters are truncated to PIX_ADDR_W/WEI_ADDR_W; overflow wraps silently.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined: adds output checksum [DATA_W+ADDR_W-1:0], the signed sum of all words returned in the current job. It is cleared on an accepted start and on rst, and is final and stable from the done pulse until the next start.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Pixel job, RD_LAT=1, base=100, count=4, RAM[100..103]=5,-3,7,0 -> we_p on 4 consecutive cycles starting 2 cycles after start; addrp 0..3; dp 5,-3,7,0; done 1 cycle after last we_p.
- Weight job, count=18, group_len=0, RAM words 1..18 -> exactly 2 we_w; addrw 0 has lanes MSB->LSB = 1..9; addrw 1 has 10..18.
- Dense job, group_len=3, count=7, words 1..7 -> we_w x3: lanes (1,2,3,0..), (4,5,6,0..), (7,0,0..) flush; addrw 0,1,2.
- RD_LAT=3, pixel count=2 -> first we_p 4 cycles after start; start pulsed while busy -> ignored, no second job; count=0 -> done only, no strobes.
- rst asserted mid weight job after 5 words -> next cycle all outputs 0 with no we_w/done; a fresh job afterwards starts addrw at 0.
- LOADER_CHECKSUM_EN, words 5,-3,7,0 -> checksum=9 at done; a new start clears it to 0.

Source files
------------

// File: rtl/ram_to_mem_loader.sv
// ram_to_mem_loader
//   Streams a contiguous region of the external parameter RAM into either the
//   pixel database (one word per write) or the weight database (up to KERNEL_N
//   words packed per write, first word in the MSB lane). A job is requested
//   with a one-cycle start in IDLE. base_addr, word_count, mode and group_len
//   are latched at that point. One RAM read is issued per clock.
//
//   Optional feature: define LOADER_CHECKSUM_EN to add the checksum output.
//   It is the signed sum of all words returned in the current job.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               job request (IDLE only)
//   mode                0 = pixel job, 1 = weight job
//   base_addr           first RAM address of the job
//   word_count          words to transfer (0 = empty job)
//   group_len           words per packed weight (0 or >KERNEL_N -> KERNEL_N)
//   ram_addr, ram_re    RAM read request
//   ram_data            RAM read data, valid RD_LAT cycles after ram_re
//   we_p, dp, addrp     pixel database write port
//   we_w, dw, addrw     weight database write port
//   checksum            job word sum (LOADER_CHECKSUM_EN only)
//   busy, done          job status
module ram_to_mem_loader #(
  parameter int unsigned DATA_W     = 11,
  parameter int unsigned KERNEL_N   = 9,
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned PIX_ADDR_W = 13,
  parameter int unsigned WEI_ADDR_W = 10,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                mode,
  input  logic        [ADDR_W-1:0]            base_addr,
  input  logic        [ADDR_W-1:0]            word_count,
  input  logic        [3:0]                   group_len,
  output logic        [ADDR_W-1:0]            ram_addr,
  output logic                                ram_re,
  input  logic signed [DATA_W-1:0]            ram_data,
  output logic                                we_p,
  output logic signed [DATA_W-1:0]            dp,
  output logic        [PIX_ADDR_W-1:0]        addrp,
  output logic                                we_w,
  output logic signed [DATA_W*KERNEL_N-1:0]   dw,
  output logic        [WEI_ADDR_W-1:0]        addrw,
`ifdef LOADER_CHECKSUM_EN
  output logic signed [DATA_W+ADDR_W-1:0]     checksum,
`endif
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned LaneW = (KERNEL_N > 1) ? $clog2(KERNEL_N) : 1;
  localparam int unsigned PackW = DATA_W * KERNEL_N;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e r_state, w_state_next;

  logic                     r_mode;
  logic [ADDR_W-1:0]        r_base, r_cnt, r_rd_idx;
  logic [LaneW-1:0]         r_last_lane, r_lane, w_last_lane;
  logic [RD_LAT-1:0]        r_vld;
  logic [PIX_ADDR_W-1:0]    r_wr_idx, r_addrp;
  logic [WEI_ADDR_W-1:0]    r_grp, r_addrw;
  logic [PackW-1:0]         r_buf, w_buf_ins, r_dw;
  logic signed [DATA_W-1:0] r_dp;
  logic                     r_we_p, r_we_w;
  logic                     w_accept, w_last_rd, w_ret, w_pending, w_flush;

  always_comb begin
    w_accept  = (r_state == StIdle) && start;
    w_last_rd = (r_rd_idx == (r_cnt - ADDR_W'(1)));
    w_ret     = r_vld[RD_LAT-1];
    w_pending = |r_vld;
    // A partially filled pack buffer is written out once all reads have returned.
    w_flush   = (r_state == StDrain) && !w_pending && r_mode && (r_lane != '0);

    if ((group_len == 4'd0) || (32'(group_len) > KERNEL_N)) begin
      w_last_lane = LaneW'(KERNEL_N - 1);
    end else begin
      w_last_lane = LaneW'(group_len - 4'd1);
    end

    // Lane 0 is the MSB lane; lanes fill downwards.
    w_buf_ins = r_buf;
    for (int l = 0; l < KERNEL_N; l++) begin
      if (r_lane == LaneW'(l)) begin
        w_buf_ins[DATA_W*(KERNEL_N-1-l) +: DATA_W] = ram_data;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and decoded outputs
  always_comb begin
    w_state_next = r_state;
    ram_re       = 1'b0;
    ram_addr     = '0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = (word_count == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        ram_re   = 1'b1;
        ram_addr = r_base + r_rd_idx;
        if (w_last_rd) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (!w_pending && !w_flush) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath: job latch, read counter, return tracking, write ports
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= 1'b0;
      r_base      <= '0;
      r_cnt       <= '0;
      r_last_lane <= '0;
      r_rd_idx    <= '0;
      r_vld       <= '0;
      r_wr_idx    <= '0;
      r_grp       <= '0;
      r_lane      <= '0;
      r_buf       <= '0;
      r_we_p      <= 1'b0;
      r_dp        <= '0;
      r_addrp     <= '0;
      r_we_w      <= 1'b0;
      r_dw        <= '0;
      r_addrw     <= '0;
    end else begin
      r_we_p <= 1'b0;
      r_we_w <= 1'b0;

      if (w_accept) begin
        r_mode      <= mode;
        r_base      <= base_addr;
        r_cnt       <= word_count;
        r_last_lane <= w_last_lane;
        r_rd_idx    <= '0;
        r_wr_idx    <= '0;
        r_grp       <= '0;
        r_lane      <= '0;
        r_buf       <= '0;
      end

      if (r_state == StIssue) begin
        r_rd_idx <= r_rd_idx + ADDR_W'(1);
      end

      // Read-valid pipeline, aligned with the RAM latency.
      r_vld[0] <= ram_re;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end

      if (w_ret) begin
        if (!r_mode) begin
          r_we_p   <= 1'b1;
          r_dp     <= ram_data;
          r_addrp  <= r_wr_idx;
          r_wr_idx <= r_wr_idx + PIX_ADDR_W'(1);
        end else if (r_lane == r_last_lane) begin
          r_we_w  <= 1'b1;
          r_dw    <= w_buf_ins;
          r_addrw <= r_grp;
          r_grp   <= r_grp + WEI_ADDR_W'(1);
          r_buf   <= '0;
          r_lane  <= '0;
        end else begin
          r_buf  <= w_buf_ins;
          r_lane <= r_lane + LaneW'(1);
        end
      end

      if (w_flush) begin
        r_we_w  <= 1'b1;
        r_dw    <= r_buf;
        r_addrw <= r_grp;
        r_grp   <= r_grp + WEI_ADDR_W'(1);
        r_buf   <= '0;
        r_lane  <= '0;
      end
    end
  end

  assign we_p  = r_we_p;
  assign dp    = r_dp;
  assign addrp = r_addrp;
  assign we_w  = r_we_w;
  assign dw    = r_dw;
  assign addrw = r_addrw;

`ifdef LOADER_CHECKSUM_EN
  logic signed [DATA_W+ADDR_W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_sum <= '0;
    end else if (w_ret) begin
      r_sum <= r_sum + (DATA_W+ADDR_W)'(ram_data);
    end
  end

  assign checksum = r_sum;
`endif

endmodule

// File: tb/tb_ram_to_mem_loader.sv
// Bench for ram_to_mem_loader: two instances (RD_LAT=1 and RD_LAT=3) share the
// job inputs. Each has its own RAM model over a shared memory image. Expected
// write/done events, including their cycle, are queued per instance when a
// job is launched and popped as the instance produces them.
module tb_ram_to_mem_loader;
  localparam int DW = 11, KN = 9, AW = 13, PW = 13, WW = 10;
  localparam int PKW = DW * KN, SW = DW + AW;
  localparam int KPIX = 0, KWEI = 1, KDONE = 2;

  typedef struct {
    int               cyc;
    int               kind;
    logic [PKW-1:0]   data;
    int               addr;
  } ev_t;

  logic clk = 1'b0;
  logic rst, start, mode;
  logic [AW-1:0] base_addr, word_count;
  logic [3:0] group_len;

  logic [AW-1:0]         ram_addr0, ram_addr1;
  logic                  ram_re0, ram_re1;
  logic signed [DW-1:0]  ram_data0, ram_data1, p3a, p3b;
  logic                  we_p0, we_p1, we_w0, we_w1, busy0, busy1, done0, done1;
  logic signed [DW-1:0]  dp0, dp1;
  logic [PW-1:0]         addrp0, addrp1;
  logic signed [PKW-1:0] dw0, dw1;
  logic [WW-1:0]         addrw0, addrw1;
  logic [PKW-1:0]        dd0, dd1;
`ifdef LOADER_CHECKSUM_EN
  logic signed [SW-1:0]  checksum0, checksum1;
`endif

  logic signed [DW-1:0] mem [0:(1<<AW)-1];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  ev_t q0[$];
  ev_t q1[$];

  ram_to_mem_loader #(
    .DATA_W(DW), .KERNEL_N(KN), .ADDR_W(AW), .PIX_ADDR_W(PW), .WEI_ADDR_W(WW), .RD_LAT(1)
  ) u_dut_lat1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .word_count(word_count), .group_len(group_len), .ram_addr(ram_addr0), .ram_re(ram_re0),
    .ram_data(ram_data0), .we_p(we_p0), .dp(dp0), .addrp(addrp0), .we_w(we_w0), .dw(dw0),
    .addrw(addrw0),
`ifdef LOADER_CHECKSUM_EN
    .checksum(checksum0),
`endif
    .busy(busy0), .done(done0)
  );

  ram_to_mem_loader #(
    .DATA_W(DW), .KERNEL_N(KN), .ADDR_W(AW), .PIX_ADDR_W(PW), .WEI_ADDR_W(WW), .RD_LAT(3)
  ) u_dut_lat3 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .word_count(word_count), .group_len(group_len), .ram_addr(ram_addr1), .ram_re(ram_re1),
    .ram_data(ram_data1), .we_p(we_p1), .dp(dp1), .addrp(addrp1), .we_w(we_w1), .dw(dw1),
    .addrw(addrw1),
`ifdef LOADER_CHECKSUM_EN
    .checksum(checksum1),
`endif
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models
  always @(posedge clk) ram_data0 <= ram_re0 ? mem[ram_addr0] : '0;
  always @(posedge clk) begin
    p3a       <= ram_re1 ? mem[ram_addr1] : '0;
    p3b       <= p3a;
    ram_data1 <= p3b;
  end

  function automatic logic [PKW-1:0] zx(input logic [DW-1:0] v);
    zx = '0;
    zx[DW-1:0] = v;
  endfunction

  function automatic logic [PKW-1:0] zs(input logic [SW-1:0] v);
    zs = '0;
    zs[SW-1:0] = v;
  endfunction

`ifdef LOADER_CHECKSUM_EN
  always_comb begin
    dd0 = zs(checksum0);
    dd1 = zs(checksum1);
  end
`else
  always_comb begin
    dd0 = '0;
    dd1 = '0;
  end
`endif

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic ev_t mk(input int c, input int kd, input logic [PKW-1:0] d, input int a);
    mk.cyc = c;
    mk.kind = kd;
    mk.data = d;
    mk.addr = a;
  endfunction

  task automatic push(input int k, input ev_t e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic observe(input int k, input int kind, input logic [PKW-1:0] data, input int addr);
    ev_t e;
    string u;
    u = (k == 0) ? "lat1" : "lat3";
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      check_eq({u, " unexpected event kind"}, 128'(kind), 128'(99));
    end else begin
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      check_eq({u, " event kind"}, 128'(kind), 128'(e.kind));
      check_eq({u, " event cycle"}, 128'(cyc), 128'(e.cyc));
      check_eq({u, " event addr"}, 128'(addr), 128'(e.addr));
      check_eq({u, " event data"}, 128'(data), 128'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (we_p0 === 1'b1) observe(0, KPIX, zx(dp0), int'(addrp0));
    if (we_w0 === 1'b1) observe(0, KWEI, dw0, int'(addrw0));
    if (done0 === 1'b1) observe(0, KDONE, dd0, 0);
    if (we_p1 === 1'b1) observe(1, KPIX, zx(dp1), int'(addrp1));
    if (we_w1 === 1'b1) observe(1, KWEI, dw1, int'(addrw1));
    if (done1 === 1'b1) observe(1, KDONE, dd1, 0);
  end

  // Reference model of one job: queue every strobe and the done pulse with its cycle.
  task automatic push_job(input int k, input int lat, input int s, input logic m, input int base,
                          input int cnt, input int gl);
    logic [PKW-1:0] pk;
    logic signed [DW-1:0] w;
    logic signed [SW-1:0] sum;
    int lane, grp, g, t_last;
    g = (gl == 0 || gl > KN) ? KN : gl;
    pk = '0;
    lane = 0;
    grp = 0;
    sum = '0;
    t_last = s - 1;
    for (int i = 0; i < cnt; i++) begin
      w = mem[(base + i) % (1 << AW)];
      sum = sum + SW'(w);
      if (!m) begin
        push(k, mk(s + lat + 1 + i, KPIX, zx(w), i % (1 << PW)));
        t_last = s + lat + 1 + i;
      end else begin
        pk[(KN-1-lane)*DW +: DW] = w;
        lane++;
        if (lane == g) begin
          push(k, mk(s + lat + 1 + i, KWEI, pk, grp % (1 << WW)));
          t_last = s + lat + 1 + i;
          grp++;
          pk = '0;
          lane = 0;
        end
      end
    end
    if (m && lane != 0) begin
      push(k, mk(s + lat + cnt + 1, KWEI, pk, grp % (1 << WW)));
      t_last = s + lat + cnt + 1;
    end
`ifdef LOADER_CHECKSUM_EN
    push(k, mk(t_last + 1, KDONE, zs(sum), 0));
`else
    push(k, mk(t_last + 1, KDONE, '0, 0));
`endif
  endtask

  task automatic run_job(input logic m, input int base, input int cnt, input int gl,
                         input bit poke);
    int s, guard;
    @(negedge clk);
    mode = m;
    base_addr = AW'(base);
    word_count = AW'(cnt);
    group_len = 4'(gl);
    start = 1'b1;
    s = cyc + 1;
    push_job(0, 1, s, m, base, cnt, gl);
    push_job(1, 3, s, m, base, cnt, gl);
    @(negedge clk);
    start = 1'b0;
    // Disturb the job inputs; the job must run on the latched copies.
    mode = ~m;
    base_addr = AW'($urandom);
    word_count = AW'($urandom);
    group_len = 4'($urandom);
    check_eq("lat1 busy after start", 128'(busy0), 128'(1));
    check_eq("lat3 busy after start", 128'(busy1), 128'(1));
`ifdef LOADER_CHECKSUM_EN
    check_eq("lat1 checksum cleared", 128'(checksum0), 128'(0));
    check_eq("lat3 checksum cleared", 128'(checksum1), 128'(0));
`endif
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) begin
      check_eq("job timeout", 128'(0), 128'(1));
      q0.delete();
      q1.delete();
    end
    repeat (4) @(negedge clk);
    check_eq("lat1 idle after job", 128'(busy0), 128'(0));
    check_eq("lat3 idle after job", 128'(busy1), 128'(0));
  endtask

  task automatic zero_dut(input string tag, input logic re, input logic [AW-1:0] addr,
                          input logic wep, input logic [DW-1:0] d, input logic wew,
                          input logic [PKW-1:0] w, input logic [PW-1:0] ap,
                          input logic [WW-1:0] aw, input logic b, input logic dn);
    check_eq({tag, " ram_re"}, 128'(re), 128'(0));
    check_eq({tag, " ram_addr"}, 128'(addr), 128'(0));
    check_eq({tag, " we_p"}, 128'(wep), 128'(0));
    check_eq({tag, " dp"}, 128'(d), 128'(0));
    check_eq({tag, " we_w"}, 128'(wew), 128'(0));
    check_eq({tag, " dw"}, 128'(w), 128'(0));
    check_eq({tag, " addrp"}, 128'(ap), 128'(0));
    check_eq({tag, " addrw"}, 128'(aw), 128'(0));
    check_eq({tag, " busy"}, 128'(b), 128'(0));
    check_eq({tag, " done"}, 128'(dn), 128'(0));
  endtask

  task automatic check_all_zero(input string tag);
    zero_dut({tag, " lat1"}, ram_re0, ram_addr0, we_p0, dp0, we_w0, dw0, addrp0, addrw0,
             busy0, done0);
    zero_dut({tag, " lat3"}, ram_re1, ram_addr1, we_p1, dp1, we_w1, dw1, addrp1, addrw1,
             busy1, done1);
`ifdef LOADER_CHECKSUM_EN
    check_eq({tag, " lat1 checksum"}, 128'(checksum0), 128'(0));
    check_eq({tag, " lat3 checksum"}, 128'(checksum1), 128'(0));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    base_addr = '0;
    word_count = '0;
    group_len = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[100] = 11'sd5;
    mem[101] = -11'sd3;
    mem[102] = 11'sd7;
    mem[103] = 11'sd0;
    for (int i = 0; i < 18; i++) mem[200 + i] = DW'(i + 1);
    for (int i = 0; i < 7; i++) mem[300 + i] = DW'(i + 1);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    run_job(1'b0, 100, 4, 0, 1'b0);      // pixel 5,-3,7,0
    run_job(1'b1, 200, 18, 0, 1'b0);     // two full 9-word kernels
    run_job(1'b1, 300, 7, 3, 1'b0);      // dense rows of 3 with flush
    run_job(1'b0, 400, 2, 0, 1'b1);      // start pulsed while busy
    run_job(1'b0, 0, 0, 0, 1'b0);        // empty pixel job
    run_job(1'b1, 500, 0, 5, 1'b0);      // empty weight job
    run_job(1'b0, 8190, 4, 0, 1'b0);     // RAM address wrap
    run_job(1'b1, 600, 10, 4, 1'b0);     // groups of 4, 2-word flush
    run_job(1'b1, 700, 9, 12, 1'b0);     // oversize group_len -> KERNEL_N

    // Abort a weight job after five words have returned on the latency-1 unit.
    @(negedge clk);
    mode = 1'b1;
    base_addr = AW'(200);
    word_count = AW'(18);
    group_len = 4'd0;
    start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid-job reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_job(1'b1, 300, 6, 3, 1'b0);      // fresh job restarts addrw at 0

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
